o_buf_controller: RTL
=====================

# o_buf_controller

Video output counterpart of the input linebuffer controller. It generates raster timing (hsync, vsync, vde) for a fixed mode and reads 32-bit words from a ping-pong output linebuffer in BRAM. Each word is unpacked into 4 8-bit pixels on `o_data`. The processing system refills each line bank by DMA from the DRAM framebuffer after a `line_done` interrupt.

## Interface
- `ADDRESS_WIDTH`, 10: BRAM word address width. MSB is the bank select; the low bits are the word index.
- `H_ACTIVE`, 640: active pixels per line. Must be a multiple of 4 and ≤ 4·2^(ADDRESS_WIDTH-1).
- `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal front porch, sync and back porch, in pixels. Each ≥ 1.
- `V_ACTIVE`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical timing, in lines. Each ≥ 1.
- `pclk` input, 1 bit: pixel clock. The only clock.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `en` input, 1 bit: run enable.
- `re` output, 1 bit: BRAM read enable.
- `addr` output, ADDRESS_WIDTH bits: BRAM word address, `{bank, word_index}`.
- `rd_data` input, 32 bits: BRAM read data. Valid exactly 1 cycle after `re`.
- `hsync` output, 1 bit: horizontal sync, active-low.
- `vsync` output, 1 bit: vertical sync, active-low.
- `vde` output, 1 bit: video data enable.
- `o_data` output, 8 bits: pixel data. 0 whenever `vde`=0.
- `line_done` output, 1 bit: 1-cycle interrupt pulse; a bank has been fully read.
- `done_bank` output, 1 bit: bank just released. Updated with `line_done` and held until the next `line_done`.
- `frame_start` output, 1 bit: 1-cycle pulse on the first vsync-low cycle.

## Operation
- Counters:
  - `h_cnt` runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - `v_cnt` runs 0..V_TOTAL-1 and increments when `h_cnt` wraps.
  - `v_cnt` wraps to 0 after V_TOTAL-1.
- Horizontal region order: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch.
- Vertical region order: the same, in lines.
- Active pixel: `h_cnt`<H_ACTIVE and `v_cnt`<V_ACTIVE.
- `vsync` is low for every cycle of the V_SYNC lines. `hsync` is low in the horizontal sync region on every line, including vertical blanking lines.
- Reads:
  - `re`=1 on active pixels with `h_cnt[1:0]`=0.
  - `addr` = {bank, h_cnt/4}.
  - One read per 4 pixels; no reads during blanking.
- Unpacking: pixel 0 of a word is rd_data[31:24], pixel 1 [23:16], pixel 2 [15:8], pixel 3 [7:0]. This matches the input controller's packing.
- Bank handling:
  - `bank` is forced to 0 at `h_cnt`=0, `v_cnt`=0.
  - `bank` toggles after the last active pixel of each active line.
  - `line_done` pulses with `done_bank` = the bank just read.
- `en`=0 (synchronous):
  - Counters are held at 0, `bank`=0, and the pipeline is flushed.
  - From the next edge, outputs take their reset values.
  - On `en` 0→1, timing restarts at `h_cnt`=0, `v_cnt`=0.
- Reset values: `re`=0, `addr`=0, `hsync`=1, `vsync`=1, `vde`=0, `o_data`=0, `line_done`=0, `done_bank`=0, `frame_start`=0.
- Reset applies immediately on `reset_n` low, mid-frame included.

## Timing
- Pipeline: counter value at edge t → `re`/`addr` registered at t+1 → `rd_data` valid at t+2 → `o_data`/`vde`/`hsync`/`vsync` registered at t+3.
- `hsync`, `vsync` and `vde` go through the same 3-stage delay, so they stay mutually aligned with pixel data.
- `line_done` is asserted in the same cycle as the last `vde`=1 cycle of the line.
- `frame_start` is asserted in the same cycle as the first `vsync`=0 output cycle.
- Pixel throughput: 1 pixel per cycle. No back-pressure.
- The captured word is held in an unpack register loaded only on the delayed `re`; bytes are selected by the delayed `h_cnt[1:0]`.
- Counter wrap (h and v both wrapping in the same cycle): `bank` reset to 0 takes priority over the toggle.

## Structure
- Shared video timing package holds:
  - H/V default constants.
  - H_TOTAL/V_TOTAL derived constants.
  - Sync polarity constants, shared with the input controller.
- One sub-module, `video_timing_gen`: counters plus hsync/vsync/active/frame flags. It is reused by the test pattern generator.
- The BRAM read pipeline and unpacking stay in `o_buf_controller`.

## Test plan
All scenarios use small parameters unless noted: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1, ADDRESS_WIDTH=4.
- Reset: hold `reset_n`=0 → all outputs at reset values; release with `en`=1 → first `vde`=1 exactly 3 cycles later.
- Raster: run 2 frames → 14-cycle line period; 8 `vde` cycles per active line; `hsync` low 2 cycles at offsets 10-11; `vsync` low for one full line (line 3); `frame_start` once per 70 cycles.
- Data/addresses: BRAM model bank 0 = {0x00010203, 0x04050607}, bank 1 = {0x10111213, 0x14151617} → line 0 `o_data` = 00..07 from addrs 0,1; line 1 `o_data` = 10..17 from addrs 8,9; `re` exactly 2 cycles per line.
- Interrupts: `line_done` on the last `vde` of each line; `done_bank` = 0, then 1; next frame line 0 reads bank 0 again.
- `en` mid-line: drop `en` at pixel 5 of line 1 → next edge `vde`=0, `o_data`=0, `re`=0; re-raise → restart at line 0, bank 0.
- Async reset mid-pixel: `reset_n` low between edges → outputs at reset values before the next `pclk` edge.

Source files
------------

// File: rtl/o_buf_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : o_buf_controller_pkg
// Description : Shared video timing package. Default raster constants for the
//               640x480 mode, derived line/frame totals, sync polarity shared
//               with the input linebuffer controller, the per-pixel control
//               bundle carried down the output pipeline, and the word-to-pixel
//               unpack helper.
// Revision    : 1.0 - initial release
// ============================================================================
package o_buf_controller_pkg;

    // Default horizontal timing, in pixels
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    // Default vertical timing, in lines
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Both syncs are active-low; the input controller decodes the same levels.
    localparam logic SYNC_ACTIVE = 1'b0;
    localparam logic SYNC_IDLE   = 1'b1;

    localparam int PIX_W         = 8;
    localparam int BRAM_W        = 32;
    localparam int PIX_PER_WORD  = BRAM_W / PIX_W;

    // Per-pixel control travelling alongside the BRAM read so that syncs,
    // data enable and interrupts leave the block aligned with the pixel.
    typedef struct packed {
        logic       vde;    // active pixel
        logic       hsync;  // horizontal sync level
        logic       vsync;  // vertical sync level
        logic       fs;     // first cycle of vertical sync
        logic       last;   // last active pixel of an active line
        logic       bank;   // linebuffer bank this pixel is read from
        logic [1:0] sel;    // pixel position inside the 32-bit word
    } vid_ctl_t;

    localparam vid_ctl_t VID_CTL_IDLE = '{
        vde:   1'b0,
        hsync: SYNC_IDLE,
        vsync: SYNC_IDLE,
        fs:    1'b0,
        last:  1'b0,
        bank:  1'b0,
        sel:   2'b00
    };

    // Pixel 0 sits in the most significant byte, matching the packing used
    // by the input controller when it fills the framebuffer.
    function automatic logic [PIX_W-1:0] unpack_pixel(input logic [BRAM_W-1:0] word,
                                                      input logic [1:0]        sel);
        logic [PIX_W-1:0] pix;
        case (sel)
            2'd0:    pix = word[31:24];
            2'd1:    pix = word[23:16];
            2'd2:    pix = word[15:8];
            default: pix = word[7:0];
        endcase
        return pix;
    endfunction

endpackage
`default_nettype wire

// File: rtl/o_buf_controller_timing.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Raster counters and region decode for a fixed video mode.
//               Shared by the output linebuffer controller and the test
//               pattern generator. All decoded flags are combinational from
//               the registered counters (pipeline stage 0).
// Revision    : 1.0 - initial release
// Ports       :
//   pclk_i        pixel clock
//   reset_ni      asynchronous active-low reset
//   en_i          run enable; counters held at 0 while low
//   h_cnt_o       pixel counter, 0..H_TOTAL-1
//   v_cnt_o       line counter, 0..V_TOTAL-1
//   active_o      current pixel lies in the active picture
//   hsync_o       horizontal sync level for the current pixel
//   vsync_o       vertical sync level for the current pixel
//   frame_start_o first pixel of the vertical sync region
//   line_end_o    last active pixel of an active line
// ============================================================================
module video_timing_gen
    import o_buf_controller_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int H_CNT_W  = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int V_CNT_W  = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic               pclk_i,
    input  logic               reset_ni,
    input  logic               en_i,
    output logic [H_CNT_W-1:0] h_cnt_o,
    output logic [V_CNT_W-1:0] v_cnt_o,
    output logic               active_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               frame_start_o,
    output logic               line_end_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_CNT_W-1:0] H_LAST     = H_CNT_W'(H_TOTAL - 1);
    localparam logic [H_CNT_W-1:0] H_ACT_END  = H_CNT_W'(H_ACTIVE);
    localparam logic [H_CNT_W-1:0] H_ACT_LAST = H_CNT_W'(H_ACTIVE - 1);
    localparam logic [H_CNT_W-1:0] HS_START   = H_CNT_W'(H_ACTIVE + H_FP);
    localparam logic [H_CNT_W-1:0] HS_END     = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [V_CNT_W-1:0] V_LAST     = V_CNT_W'(V_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_ACT_END  = V_CNT_W'(V_ACTIVE);
    localparam logic [V_CNT_W-1:0] VS_START   = V_CNT_W'(V_ACTIVE + V_FP);
    localparam logic [V_CNT_W-1:0] VS_END     = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic               w_h_last;
    logic               w_v_last;
    logic               w_v_active;
    logic               w_in_hs;
    logic               w_in_vs;

    assign w_h_last = (h_cnt_q == H_LAST);
    assign w_v_last = (v_cnt_q == V_LAST);

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!en_i) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (w_h_last) begin
            h_cnt_d = '0;
            v_cnt_d = w_v_last ? '0 : v_cnt_q + 1'b1;
        end else begin
            h_cnt_d = h_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign w_v_active = (v_cnt_q < V_ACT_END);
    assign w_in_hs    = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    assign w_in_vs    = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);

    assign h_cnt_o       = h_cnt_q;
    assign v_cnt_o       = v_cnt_q;
    assign active_o      = (h_cnt_q < H_ACT_END) && w_v_active;
    // hsync keeps running through vertical blanking
    assign hsync_o       = w_in_hs ? SYNC_ACTIVE : SYNC_IDLE;
    assign vsync_o       = w_in_vs ? SYNC_ACTIVE : SYNC_IDLE;
    assign frame_start_o = (v_cnt_q == VS_START) && (h_cnt_q == '0);
    assign line_end_o    = (h_cnt_q == H_ACT_LAST) && w_v_active;

endmodule
`default_nettype wire

// File: rtl/o_buf_controller.sv
`default_nettype none
// ============================================================================
// Module      : o_buf_controller
// Description : Video output linebuffer controller. Generates raster timing,
//               reads 32-bit words from a ping-pong BRAM linebuffer (one read
//               per 4 pixels) and unpacks them to one 8-bit pixel per clock.
//               Raises line_done when a bank has been fully read so software
//               can refill it from the framebuffer.
//               Pipeline: counters (t) -> re/addr (t+1) -> rd_data (t+2)
//               -> o_data/vde/hsync/vsync (t+3).
// Revision    : 1.0 - initial release
// Ports       :
//   pclk        pixel clock
//   reset_n     asynchronous active-low reset
//   en          run enable; low flushes the pipeline and restarts timing
//   re          BRAM read enable
//   addr        BRAM word address {bank, word_index}
//   rd_data     BRAM read data, valid one cycle after re
//   hsync       horizontal sync, active-low
//   vsync       vertical sync, active-low
//   vde         video data enable
//   o_data      pixel data, 0 outside active video
//   line_done   one-cycle pulse: a bank has been fully read
//   done_bank   bank released by the latest line_done
//   frame_start one-cycle pulse on the first vsync-low cycle
// ============================================================================
module o_buf_controller
    import o_buf_controller_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 10,
    parameter int H_ACTIVE      = DEF_H_ACTIVE,
    parameter int H_FP          = DEF_H_FP,
    parameter int H_SYNC        = DEF_H_SYNC,
    parameter int H_BP          = DEF_H_BP,
    parameter int V_ACTIVE      = DEF_V_ACTIVE,
    parameter int V_FP          = DEF_V_FP,
    parameter int V_SYNC        = DEF_V_SYNC,
    parameter int V_BP          = DEF_V_BP
) (
    input  logic                     pclk,
    input  logic                     reset_n,
    input  logic                     en,
    output logic                     re,
    output logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [BRAM_W-1:0]        rd_data,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     vde,
    output logic [PIX_W-1:0]         o_data,
    output logic                     line_done,
    output logic                     done_bank,
    output logic                     frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_CNT_W = $clog2(H_TOTAL);
    localparam int V_CNT_W = $clog2(V_TOTAL);
    localparam int IDX_W   = ADDRESS_WIDTH - 1;

    localparam logic [H_CNT_W-1:0] H_LAST = H_CNT_W'(H_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_LAST = V_CNT_W'(V_TOTAL - 1);

    // ------------------------------------------------------------------
    // Stage 0: raster timing
    // ------------------------------------------------------------------
    logic [H_CNT_W-1:0] h_cnt;
    logic [V_CNT_W-1:0] v_cnt;
    logic               tg_active;
    logic               tg_hsync;
    logic               tg_vsync;
    logic               tg_frame_start;
    logic               tg_line_end;
    logic               frame_end;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .H_CNT_W  (H_CNT_W),
        .V_CNT_W  (V_CNT_W)
    ) u_timing (
        .pclk_i        (pclk),
        .reset_ni      (reset_n),
        .en_i          (en),
        .h_cnt_o       (h_cnt),
        .v_cnt_o       (v_cnt),
        .active_o      (tg_active),
        .hsync_o       (tg_hsync),
        .vsync_o       (tg_vsync),
        .frame_start_o (tg_frame_start),
        .line_end_o    (tg_line_end)
    );

    // Counters are about to wrap to (0,0) on the next edge.
    assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic                     bank_q,        bank_d;
    vid_ctl_t                 s0;
    vid_ctl_t                 s1_q,          s1_d;
    logic                     re_q,          re_d;
    logic [ADDRESS_WIDTH-1:0] addr_q,        addr_d;
    vid_ctl_t                 s2_q,          s2_d;
    logic                     rvalid_q,      rvalid_d;
    logic [BRAM_W-1:0]        word_q,        word_d;
    logic [PIX_W-1:0]         o_data_q,      o_data_d;
    logic                     vde_q,         vde_d;
    logic                     hsync_q,       hsync_d;
    logic                     vsync_q,       vsync_d;
    logic                     line_done_q,   line_done_d;
    logic                     done_bank_q,   done_bank_d;
    logic                     frame_start_q, frame_start_d;

    assign s0 = '{
        vde:   tg_active,
        hsync: tg_hsync,
        vsync: tg_vsync,
        fs:    tg_frame_start,
        last:  tg_line_end,
        bank:  bank_q,
        sel:   h_cnt[1:0]
    };

    always_comb begin
        // Bank: the frame wrap reset wins over the end-of-line toggle.
        bank_d = bank_q;
        if (frame_end) begin
            bank_d = 1'b0;
        end else if (tg_line_end) begin
            bank_d = ~bank_q;
        end

        // Stage 1: issue one BRAM read at the first pixel of each word.
        s1_d   = s0;
        re_d   = s0.vde && (s0.sel == 2'b00);
        addr_d = re_d ? {bank_q, IDX_W'(h_cnt >> 2)} : addr_q;

        // Stage 2: rd_data for the stage-1 read becomes valid here.
        s2_d     = s1_q;
        rvalid_d = re_q;

        // Stage 3: pixel 0 of a word is taken straight from the BRAM output
        // while the word is captured; pixels 1..3 come from the held copy.
        word_d        = rvalid_q ? rd_data : word_q;
        o_data_d      = s2_q.vde ? unpack_pixel(word_d, s2_q.sel) : '0;
        vde_d         = s2_q.vde;
        hsync_d       = s2_q.hsync;
        vsync_d       = s2_q.vsync;
        line_done_d   = s2_q.last;
        frame_start_d = s2_q.fs;
        done_bank_d   = s2_q.last ? s2_q.bank : done_bank_q;

        // Disabled: flush everything back to idle levels on this edge.
        if (!en) begin
            bank_d        = 1'b0;
            s1_d          = VID_CTL_IDLE;
            re_d          = 1'b0;
            addr_d        = '0;
            s2_d          = VID_CTL_IDLE;
            rvalid_d      = 1'b0;
            word_d        = '0;
            o_data_d      = '0;
            vde_d         = 1'b0;
            hsync_d       = SYNC_IDLE;
            vsync_d       = SYNC_IDLE;
            line_done_d   = 1'b0;
            frame_start_d = 1'b0;
            done_bank_d   = 1'b0;
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            bank_q        <= 1'b0;
            s1_q          <= VID_CTL_IDLE;
            re_q          <= 1'b0;
            addr_q        <= '0;
            s2_q          <= VID_CTL_IDLE;
            rvalid_q      <= 1'b0;
            word_q        <= '0;
            o_data_q      <= '0;
            vde_q         <= 1'b0;
            hsync_q       <= SYNC_IDLE;
            vsync_q       <= SYNC_IDLE;
            line_done_q   <= 1'b0;
            done_bank_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            bank_q        <= bank_d;
            s1_q          <= s1_d;
            re_q          <= re_d;
            addr_q        <= addr_d;
            s2_q          <= s2_d;
            rvalid_q      <= rvalid_d;
            word_q        <= word_d;
            o_data_q      <= o_data_d;
            vde_q         <= vde_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_done_q   <= line_done_d;
            done_bank_q   <= done_bank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign re          = re_q;
    assign addr        = addr_q;
    assign o_data      = o_data_q;
    assign vde         = vde_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_done   = line_done_q;
    assign done_bank   = done_bank_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire
